// File: rtl/mem_stage_pkg.sv
// Shared MS-stage definitions: bus-width macros (the head.h set), ld_op bit indices and packed bus layouts.
// Optional build macro honoured by mem_stage: MS_LOAD_BYPASS_EN.
`ifndef MEM_STAGE_HEAD_H
`define MEM_STAGE_HEAD_H
`define EARRAY_W        8
`define EARRAY_ADEF     0
`define EARRAY_ALE      1
`define EARRAY_SYS      2
`define EARRAY_BRK      3
`define EARRAY_INE      4
`define EARRAY_IPE      5
`define EARRAY_INT      6
`define EARRAY_ERTN     7
`define TLB_ZIP_W       4
`define TLB_ZIP_REFETCH 3
`define TLB_ERRLEN      8
`define LD_B            4
`define LD_BU           3
`define LD_H            2
`define LD_HU           1
`define LD_W            0
`define ES2MS_BUS       129
`define MS2WS_BUS       84
`endif

package mem_stage_pkg;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0]               vaddr;
    logic [31:0]               pc;
    logic [`EARRAY_W-1:0]      except_zip;
    logic [`TLB_ZIP_W-1:0]     tlb_zip;
    logic [`TLB_ERRLEN-1:0]    tlb_exc;
    logic [4:0]                ld_op;
    logic                      mem_req;
    logic                      csr_re;
    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [31:0]               alu_result;
  } es2ms_t;

  typedef struct packed {
    logic [31:0]               vaddr;
    logic [31:0]               pc;
    logic [`EARRAY_W-1:0]      except_zip;
    logic [`TLB_ZIP_W-1:0]     tlb_zip;
    logic [`TLB_ERRLEN-1:0]    tlb_exc;
  } ms2ws_t;

  typedef struct packed {
    logic                      csr_re;
    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [31:0]               rf_wdata;
  } rf_zip_t;

  typedef struct packed {
    logic                      ld_wait;
    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [31:0]               rf_wdata;
  } fwd_zip_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks byte/half by address and sign- or zero-extends to a full word.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        ld_op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    if (ld_op[`LD_B])
      data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
    else if (ld_op[`LD_BU])
      data = {{(DATA_W-8){1'b0}}, byte_sel};
    else if (ld_op[`LD_H])
      data = {{(DATA_W-16){half_sel[15]}}, half_sel};
    else if (ld_op[`LD_HU])
      data = {{(DATA_W-16){1'b0}}, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data response, drops stale responses after flush.
// Build option: MS_LOAD_BYPASS_EN forwards load data to ID in the response cycle.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  es2ms_valid,
  input  logic [`ES2MS_BUS-1:0] es2ms_bus,
  output logic                  ms_allowin,
  input  logic                  ws_allowin,
  output logic                  ms2ws_valid,
  output logic [`MS2WS_BUS-1:0] ms2ws_bus,
  output logic [38:0]           ms_rf_zip,
  output logic [38:0]           ms_fwd_zip,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  es_req_pending,
  output logic                  ms_ex,
  input  logic                  wb_ex,
  input  logic                  ertn_flush,
  input  logic                  wb_refetch_flush
);

  es2ms_t      ms_bus_p0;
  logic        ms_valid;
  logic [1:0]  discard_cnt;
  logic        data_buf_valid;
  logic [31:0] data_buf;

  logic        flush;
  logic        resp_kept;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        cnt_dec;
  logic        ms_lost;
  logic [2:0]  cnt_sum;
  logic [31:0] load_src;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        ld_wait;
  rf_zip_t     rf_zip;
  fwd_zip_t    fwd_zip;

  function automatic logic [1:0] sat_cnt(input logic [2:0] v);
    return (v > 3'd3) ? 2'd3 : v[1:0];
  endfunction

  assign flush       = wb_ex | ertn_flush | wb_refetch_flush;
  assign resp_kept   = data_sram_data_ok & (discard_cnt == 2'd0);
  assign ms_ready_go = ~ms_bus_p0.mem_req | resp_kept | data_buf_valid;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go & ~flush;
  assign ms_leave    = ms_valid & ms_ready_go & ws_allowin;

  // A response arriving with the flush belongs to the oldest request, so MS only counts if still unanswered.
  assign cnt_dec = data_sram_data_ok & (discard_cnt != 2'd0);
  assign ms_lost = ms_valid & ms_bus_p0.mem_req & ~resp_kept & ~data_buf_valid;

  always_comb begin
    cnt_sum = {1'b0, discard_cnt} - {2'b00, cnt_dec};
    if (flush)
      cnt_sum = cnt_sum + {2'b00, ms_lost} + {2'b00, es_req_pending};
  end

  // Stage register boundary: EX -> MS
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es2ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_bus_p0 <= '0;
    end else if (es2ms_valid && ms_allowin) begin
      ms_bus_p0 <= es2ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt <= 2'd0;
    end else begin
      discard_cnt <= sat_cnt(cnt_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_buf_valid <= 1'b0;
      data_buf       <= 32'd0;
    end else if (flush || ms_leave) begin
      data_buf_valid <= 1'b0;
      data_buf       <= 32'd0;
    end else if (resp_kept && ms_valid && ms_bus_p0.mem_req && !data_buf_valid) begin
      data_buf_valid <= 1'b1;
      data_buf       <= data_sram_rdata;
    end
  end

  assign load_src = data_buf_valid ? data_buf : data_sram_rdata;

  mem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_op   (ms_bus_p0.ld_op),
    .addr_lo (ms_bus_p0.vaddr[1:0]),
    .rdata   (load_src),
    .data    (load_data)
  );

  assign rf_wdata = (|ms_bus_p0.ld_op) ? load_data : ms_bus_p0.alu_result;

`ifdef MS_LOAD_BYPASS_EN
  assign ld_wait = ms_valid & (|ms_bus_p0.ld_op) & ~ms_ready_go;
`else
  assign ld_wait = ms_valid & (|ms_bus_p0.ld_op);
`endif

  always_comb begin
    rf_zip.csr_re    = ms_bus_p0.csr_re;
    rf_zip.rf_we     = ms_bus_p0.rf_we & ms_valid;
    rf_zip.rf_waddr  = ms_bus_p0.rf_waddr;
    rf_zip.rf_wdata  = rf_wdata;
    fwd_zip.ld_wait  = ld_wait;
    fwd_zip.rf_we    = ms_bus_p0.rf_we & ms_valid;
    fwd_zip.rf_waddr = ms_bus_p0.rf_waddr;
    fwd_zip.rf_wdata = rf_wdata;
  end

  assign ms_rf_zip  = rf_zip;
  assign ms_fwd_zip = fwd_zip;
  assign ms2ws_bus  = {ms_bus_p0.vaddr, ms_bus_p0.pc, ms_bus_p0.except_zip,
                       ms_bus_p0.tlb_zip, ms_bus_p0.tlb_exc};
  assign ms_ex      = ms_valid & ((|ms_bus_p0.except_zip) | (|ms_bus_p0.tlb_exc)
                                  | ms_bus_p0.tlb_zip[`TLB_ZIP_REFETCH]);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, response buffering, flush discard, reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  es2ms_valid;
  logic [`ES2MS_BUS-1:0] es2ms_bus;
  logic                  ms_allowin;
  logic                  ws_allowin;
  logic                  ms2ws_valid;
  logic [`MS2WS_BUS-1:0] ms2ws_bus;
  logic [38:0]           ms_rf_zip;
  logic [38:0]           ms_fwd_zip;
  logic                  data_sram_data_ok;
  logic [31:0]           data_sram_rdata;
  logic                  es_req_pending;
  logic                  ms_ex;
  logic                  wb_ex;
  logic                  ertn_flush;
  logic                  wb_refetch_flush;

  es2ms_t bus;
  int checks = 0;
  int failures = 0;

`ifdef MS_LOAD_BYPASS_EN
  localparam logic LW_DOK = 1'b0;
`else
  localparam logic LW_DOK = 1'b1;
`endif

  assign es2ms_bus = bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es2ms_valid       (es2ms_valid),
    .es2ms_bus         (es2ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms2ws_valid       (ms2ws_valid),
    .ms2ws_bus         (ms2ws_bus),
    .ms_rf_zip         (ms_rf_zip),
    .ms_fwd_zip        (ms_fwd_zip),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .es_req_pending    (es_req_pending),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bus(input logic [31:0] va, input logic [4:0] op, input logic [4:0] wa);
    bus            = '0;
    bus.vaddr      = va;
    bus.pc         = 32'h1c00_0000 | va;
    bus.ld_op      = op;
    bus.mem_req    = 1'b1;
    bus.rf_we      = 1'b1;
    bus.rf_waddr   = wa;
    bus.alu_result = va;
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_ms2ws_valid"}, ms2ws_valid, 1'b0);
    chk({pfx, "_ms_ex"}, ms_ex, 1'b0);
    chk({pfx, "_rf_zip"}, ms_rf_zip, 39'd0);
    chk({pfx, "_fwd_zip"}, ms_fwd_zip, 39'd0);
    chk({pfx, "_allowin"}, ms_allowin, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; es2ms_valid = 1'b0; bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; es_req_pending = 1'b0;
    wb_ex = 1'b0; ertn_flush = 1'b0; wb_refetch_flush = 1'b0;
    step(); step();
    reset_checks("rst");
    resetn = 1'b1;
    step();

    // non-memory add
    bus = '0; bus.rf_we = 1'b1; bus.rf_waddr = 5'd5; bus.alu_result = 32'h1234;
    es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; #1;
    chk("add_valid", ms2ws_valid, 1'b1);
    chk("add_rf_zip", ms_rf_zip, {1'b0, 1'b1, 5'd5, 32'h0000_1234});
    chk("add_fwd_zip", ms_fwd_zip, {1'b0, 1'b1, 5'd5, 32'h0000_1234});
    step();
    chk("add_gone", ms2ws_valid, 1'b0);

    // ld.b at offset 3, response two cycles after entry
    load_bus(32'h0000_1003, 5'b10000, 5'd7); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; #1;
    chk("ldb_wait_valid", ms2ws_valid, 1'b0);
    chk("ldb_wait_allowin", ms_allowin, 1'b0);
    chk("ldb_ld_wait", ms_fwd_zip[38], 1'b1);
    step();
    chk("ldb_wait2_valid", ms2ws_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC; #1;
    chk("ldb_valid", ms2ws_valid, 1'b1);
    chk("ldb_wdata", ms_rf_zip[31:0], 32'hFFFF_FF80);
    chk("ldb_ld_wait_dok", ms_fwd_zip[38], LW_DOK);
    step();
    data_sram_data_ok = 1'b0; #1;
    chk("ldb_gone", ms2ws_valid, 1'b0);

    // ld.hu upper half, WB stalled across the response
    load_bus(32'h0000_2002, 5'b00010, 5'd9); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000; #1;
    chk("ldhu_valid", ms2ws_valid, 1'b1);
    chk("ldhu_allowin", ms_allowin, 1'b0);
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF; #1;
    chk("ldhu_buf_valid", ms2ws_valid, 1'b1);
    chk("ldhu_buf_wdata1", ms_rf_zip[31:0], 32'h0000_8001);
    step();
    chk("ldhu_buf_wdata2", ms_rf_zip[31:0], 32'h0000_8001);
    step();
    ws_allowin = 1'b1; #1;
    chk("ldhu_rel_wdata", ms_rf_zip[31:0], 32'h0000_8001);
    chk("ldhu_rel_allowin", ms_allowin, 1'b1);
    step();
    chk("ldhu_gone", ms2ws_valid, 1'b0);

    // ld.h sign extension
    load_bus(32'h0000_6000, 5'b00100, 5'd3); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_8001; #1;
    chk("ldh_wdata", ms_rf_zip[31:0], 32'hFFFF_8001);
    step();
    data_sram_data_ok = 1'b0;

    // flush with waiting load plus pending EX request: two responses dropped
    load_bus(32'h0000_3000, 5'b00001, 5'd10); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; es_req_pending = 1'b1; wb_ex = 1'b1; #1;
    chk("dc2_flush_valid", ms2ws_valid, 1'b0);
    step();
    wb_ex = 1'b0; es_req_pending = 1'b0;
    load_bus(32'h0000_4000, 5'b00001, 5'd11); es2ms_valid = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; #1;
    chk("dc2_allowin", ms_allowin, 1'b1);
    step();
    es2ms_valid = 1'b0; data_sram_rdata = 32'h2222_2222; #1;
    chk("dc2_drop2_valid", ms2ws_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b0; #1;
    chk("dc2_idle_valid", ms2ws_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333; #1;
    chk("dc2_third_valid", ms2ws_valid, 1'b1);
    chk("dc2_third_wdata", ms_rf_zip[31:0], 32'h3333_3333);
    step();
    data_sram_data_ok = 1'b0;

    // flush and response in the same cycle: only the EX request is dropped
    load_bus(32'h0000_5000, 5'b00001, 5'd12); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; wb_ex = 1'b1; es_req_pending = 1'b1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9999_9999; #1;
    chk("dc1_flush_valid", ms2ws_valid, 1'b0);
    step();
    wb_ex = 1'b0; es_req_pending = 1'b0; data_sram_data_ok = 1'b0;
    load_bus(32'h0000_5100, 5'b00001, 5'd13); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_AAAA; #1;
    chk("dc1_drop_valid", ms2ws_valid, 1'b0);
    step();
    data_sram_rdata = 32'h5555_5555; #1;
    chk("dc1_keep_valid", ms2ws_valid, 1'b1);
    chk("dc1_keep_wdata", ms_rf_zip[31:0], 32'h5555_5555);
    step();
    data_sram_data_ok = 1'b0;

    // exception and refetch flags
    bus = '0; bus.vaddr = 32'h0000_7000; bus.pc = 32'h1c00_0040; bus.except_zip = 8'h01;
    es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; #1;
    chk("ex_ms_ex", ms_ex, 1'b1);
    chk("ex_bus", ms2ws_bus, {32'h0000_7000, 32'h1c00_0040, 8'h01, 4'h0, 8'h00});
    bus = '0; bus.tlb_zip = 4'b1000; es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; #1;
    chk("refetch_ms_ex", ms_ex, 1'b1);
    step();
    chk("ex_clear", ms_ex, 1'b0);

    // reset while a load waits for its response
    load_bus(32'h0000_8000, 5'b00001, 5'd14); es2ms_valid = 1'b1;
    step();
    es2ms_valid = 1'b0; #1;
    chk("midrst_waiting", ms_allowin, 1'b0);
    resetn = 1'b0;
    step();
    reset_checks("midrst");
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; resetn in 1, reset, synchronous, active-low.
REQ-002 SHALL have es2ms_valid in 1, EX instruction valid; es2ms_bus in `ES2MS_BUS, {vaddr, pc, except zip, tlb zip, tlb exc, ld_op[4:0], mem_req, csr_re, rf_we, rf_waddr, alu_result}.
REQ-003 SHALL have ms_allowin out 1, MS accepts from EX; ws_allowin in 1, WB accepts.
REQ-004 SHALL have ms2ws_valid out 1; ms2ws_bus out `MS2WS_BUS, {vaddr, pc, except zip, tlb zip, tlb exc}; ms_rf_zip out 39, {csr_re, rf_we, rf_waddr, rf_wdata}.
REQ-005 SHALL have ms_fwd_zip out 39, {ld_wait, rf_we, rf_waddr, rf_wdata} to ID.
REQ-006 SHALL have data_sram_data_ok in 1; data_sram_rdata in 32.
REQ-007 SHALL have es_req_pending in 1, EX holds an address-accepted request not yet in MS; ms_ex out 1, MS holds exception/ertn/refetch (EX suppresses new store requests).
REQ-008 SHALL have wb_ex, ertn_flush, wb_refetch_flush in 1 each; flush = OR of the three.

Function
REQ-009 ms_valid SHALL clear on flush, else load es2ms_valid when ms_allowin.
REQ-010 Bus/zip registers SHALL capture es2ms_bus when es2ms_valid & ms_allowin; no capture otherwise.
REQ-011 ms_ready_go SHALL be 1 when ~mem_req, or response held (data_ok with discard_cnt==0 this cycle, or data_buf_valid).
REQ-012 ms_allowin SHALL equal ~ms_valid | (ms_ready_go & ws_allowin); ms2ws_valid SHALL equal ms_valid & ms_ready_go & ~flush.
REQ-013 A kept data_ok while ws_allowin=0 SHALL set data_buf_valid and latch rdata into data_buf; both cleared when instruction leaves MS or flush.
REQ-014 Discard counter (2 bits, saturating at 3) SHALL count responses to drop: on flush add (ms_valid & mem_req & no response held) + es_req_pending.
REQ-015 While discard_cnt>0, each data_sram_data_ok SHALL decrement counter and be ignored.
REQ-016 Flush and data_ok same cycle: data_ok belongs to oldest outstanding; if discard_cnt>0 decrement and add increment (net); if discard_cnt==0 it belongs to MS instruction, so that instruction is not counted.
REQ-017 Load align: ld_op {b,bu,h,hu,w} SHALL select byte by vaddr[1:0], half by vaddr[1]; sign-extend b/h, zero-extend bu/hu; w passes.
REQ-018 rf_wdata SHALL be aligned load data when any ld_op bit set, else alu_result.
REQ-019 ms_rf_zip.rf_we and ms_fwd_zip.rf_we SHALL be gated by ms_valid; ms_ex = ms_valid & (any except zip bit | tlb exc | refetch flag).
REQ-020 ld_wait SHALL be ms_valid & ld_op!=0 & ~ms_ready_go.

Reset
REQ-021 resetn=0 SHALL clear ms_valid, discard_cnt, data_buf_valid, data_buf, all bus registers; outputs ms2ws_valid=0, ms_ex=0, ms_rf_zip=0, ms_fwd_zip=0, ms_allowin=1.
REQ-022 Reset mid-request SHALL not track the lost response; memory interface is reset together.

Configuration
REQ-023 MS_LOAD_BYPASS_EN defined: ms_fwd_zip SHALL carry aligned load data with ld_wait=0 in the data_ok cycle; undefined: ld_wait SHALL stay 1 for loads until instruction leaves MS.

Structure
REQ-024 `ES2MS_BUS, `MS2WS_BUS, ld_op bit indices, `EARRAY_* and `TLB_ERRLEN SHALL live in head.h.
REQ-025 Load alignment SHALL be sub-module mem_load_align (combinational, ld_op+vaddr[1:0]+rdata -> 32-bit).

Verification
REQ-026 ld.b vaddr=0x..3, rdata=0x80AABBCC, data_ok 2 cycles later -> ms2ws_valid 2 cycles after entry, rf_wdata=0xFFFFFF80.
REQ-027 ld.hu vaddr[1]=1, rdata=0x8001_0000, ws_allowin=0 during data_ok for 3 cycles -> data_buf holds, rf_wdata=0x00008001 on release.
REQ-028 Load in MS waiting, es_req_pending=1, wb_ex pulse -> discard_cnt=2, next two data_ok ignored, third feeds new load.
REQ-029 wb_ex and data_ok same cycle, discard_cnt=0, es_req_pending=1 -> discard_cnt=1.
REQ-030 Non-memory add (alu_result=0x1234) -> ms2ws_valid next cycle, ms_rf_zip wdata=0x1234, ld_wait=0.
REQ-031 resetn low mid-wait -> all REQ-021 values next cycle.
